// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(8,4) SECDED encoder: each accepted byte yields two codewords, low nibble first.
// Optional error injection on every loaded codeword when HAM_ERR_INJECT_EN is defined.
module hamming_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       code_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cw_count
`ifdef HAM_ERR_INJECT_EN
  ,
  input  logic [7:0]       inject_mask
`endif
);

  typedef enum logic [1:0] {EMPTY, LO, HI} state_t;

  state_t     state, state_nxt;
  logic [7:0] code_nxt;
  logic [3:0] hi_nib, hi_nib_nxt;
  logic       out_valid_nxt;
  logic       accept;
  logic       out_hs;
  logic [7:0] mask;

  // Format: [p_all, d3, d2, d1, p2, d0, p1, p0]
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    return {^c, c};
  endfunction

`ifdef HAM_ERR_INJECT_EN
  assign mask = inject_mask;
`else
  assign mask = '0;
`endif

  assign in_ready = !rst && (state == EMPTY || (state == HI && out_ready));
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_comb begin
    state_nxt  = state;
    code_nxt   = code_out;
    hi_nib_nxt = hi_nib;
    case (state)
      LO: begin
        if (out_ready) begin
          state_nxt = HI;
          code_nxt  = encode(hi_nib) ^ mask;
        end
      end
      HI: begin
        if (out_ready) state_nxt = EMPTY;
      end
      default: ;
    endcase
    // An accept in HI overrides the drain to EMPTY, keeping one codeword per cycle.
    if (accept) begin
      state_nxt  = LO;
      code_nxt   = encode(in_data[3:0]) ^ mask;
      hi_nib_nxt = in_data[7:4];
    end
    out_valid_nxt = (state_nxt != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      code_out  <= '0;
      out_valid <= 1'b0;
      hi_nib    <= '0;
      cw_count  <= '0;
    end else begin
      state     <= state_nxt;
      code_out  <= code_nxt;
      out_valid <= out_valid_nxt;
      hi_nib    <= hi_nib_nxt;
      if (out_hs) cw_count <= cw_count + CNT_W'(1);
    end
  end

endmodule
